// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timekeeper.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

    localparam int unsigned DIGIT_W = 4;
    typedef logic [DIGIT_W-1:0] bcd_t;

    localparam int unsigned CS_MAX  = 99;
    localparam int unsigned SEC_MAX = 59;

endpackage

// File: rtl/bcd_digit_pair.sv
// Two-digit BCD counter wrapping at MAX; exposes its next value and a carry
// so a chain of pairs settles within one cycle.
module bcd_digit_pair
    import stopwatch_pkg::*;
#(
    parameter int unsigned MAX = 99
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output bcd_t tens_nxt_c,
    output bcd_t ones_nxt_c,
    output logic carry_c
);

    localparam bcd_t TENS_MAX = bcd_t'(MAX / 10);
    localparam bcd_t ONES_MAX = bcd_t'(MAX % 10);

    bcd_t tens;
    bcd_t ones;
    logic at_max_c;

    assign at_max_c = (tens == TENS_MAX) && (ones == ONES_MAX);

    always_comb begin
        tens_nxt_c = tens;
        ones_nxt_c = ones;
        carry_c    = 1'b0;
        if (clr) begin
            tens_nxt_c = '0;
            ones_nxt_c = '0;
        end else if (inc) begin
            if (at_max_c) begin
                tens_nxt_c = '0;
                ones_nxt_c = '0;
                carry_c    = 1'b1;
            end else if (ones == bcd_t'(9)) begin
                ones_nxt_c = '0;
                tens_nxt_c = tens + bcd_t'(1);
            end else begin
                ones_nxt_c = ones + bcd_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tens <= '0;
            ones <= '0;
        end else begin
            tens <= tens_nxt_c;
            ones <= ones_nxt_c;
        end
    end

endmodule

// File: rtl/stopwatch_timekeeper.sv
// Tick-driven BCD mm:ss.cc stopwatch with run/pause/clear control.
// Define STOPWATCH_LAP_EN to enable the LAP state with frozen display.
module stopwatch_timekeeper
    import stopwatch_pkg::*;
#(
    parameter int unsigned MINUTE_MAX = 59
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               start_stop,
    input  logic               clear,
    input  logic               lap,
    output logic [DIGIT_W-1:0] m_tens,
    output logic [DIGIT_W-1:0] m_ones,
    output logic [DIGIT_W-1:0] s_tens,
    output logic [DIGIT_W-1:0] s_ones,
    output logic [DIGIT_W-1:0] cs_tens,
    output logic [DIGIT_W-1:0] cs_ones,
    output logic               running,
    output logic               wrap
);

    state_t state;
    state_t state_nxt_c;
    logic   count_en_c;
    logic   clr_c;
    logic   hold_c;
    logic   cs_carry_c;
    logic   s_carry_c;
    logic   m_carry_c;
    bcd_t   cs_tens_nxt_c, cs_ones_nxt_c;
    bcd_t   s_tens_nxt_c,  s_ones_nxt_c;
    bcd_t   m_tens_nxt_c,  m_ones_nxt_c;

    // Tick counts according to the pre-edge state.
    assign count_en_c = tick && ((state == RUN) || (state == LAP));
    assign clr_c      = (state == PAUSE) && clear;

    always_comb begin
        state_nxt_c = state;
        case (state)
            IDLE: begin
                if (start_stop) state_nxt_c = RUN;
            end
            RUN: begin
                if (start_stop) state_nxt_c = PAUSE;
`ifdef STOPWATCH_LAP_EN
                else if (lap) state_nxt_c = LAP;
`endif
            end
            PAUSE: begin
                if (clear)           state_nxt_c = IDLE;
                else if (start_stop) state_nxt_c = RUN;
            end
            LAP: begin
`ifdef STOPWATCH_LAP_EN
                if (start_stop) state_nxt_c = PAUSE;
                else if (lap)   state_nxt_c = RUN;
`else
                state_nxt_c = IDLE;
`endif
            end
        endcase
    end

`ifdef STOPWATCH_LAP_EN
    // Display freezes on entering LAP and stays frozen while in it.
    assign hold_c = (state_nxt_c == LAP);
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign hold_c     = 1'b0;
`endif

    bcd_digit_pair #(.MAX(CS_MAX)) u_cs (
        .clk        (clk),
        .reset      (reset),
        .clr        (clr_c),
        .inc        (count_en_c),
        .tens_nxt_c (cs_tens_nxt_c),
        .ones_nxt_c (cs_ones_nxt_c),
        .carry_c    (cs_carry_c)
    );

    bcd_digit_pair #(.MAX(SEC_MAX)) u_s (
        .clk        (clk),
        .reset      (reset),
        .clr        (clr_c),
        .inc        (cs_carry_c),
        .tens_nxt_c (s_tens_nxt_c),
        .ones_nxt_c (s_ones_nxt_c),
        .carry_c    (s_carry_c)
    );

    bcd_digit_pair #(.MAX(MINUTE_MAX)) u_m (
        .clk        (clk),
        .reset      (reset),
        .clr        (clr_c),
        .inc        (s_carry_c),
        .tens_nxt_c (m_tens_nxt_c),
        .ones_nxt_c (m_ones_nxt_c),
        .carry_c    (m_carry_c)
    );

    // Display loads the next live time so digits lag a tick by one cycle only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            running <= 1'b0;
            wrap    <= 1'b0;
            m_tens  <= '0;
            m_ones  <= '0;
            s_tens  <= '0;
            s_ones  <= '0;
            cs_tens <= '0;
            cs_ones <= '0;
        end else begin
            state   <= state_nxt_c;
            running <= (state_nxt_c == RUN) || (state_nxt_c == LAP);
            wrap    <= m_carry_c;
            if (!hold_c) begin
                m_tens  <= m_tens_nxt_c;
                m_ones  <= m_ones_nxt_c;
                s_tens  <= s_tens_nxt_c;
                s_ones  <= s_ones_nxt_c;
                cs_tens <= cs_tens_nxt_c;
                cs_ones <= cs_ones_nxt_c;
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_timekeeper.sv
// Self-checking bench: directed plan plus random pulses against a
// centisecond-count reference model.
module tb_stopwatch_timekeeper;

    localparam int unsigned MINUTE_MAX = 1;
    localparam int LIMIT = (MINUTE_MAX + 1) * 6000;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_LAP   = 3;

    logic       clk = 1'b0;
    logic       reset, tick, start_stop, clear, lap;
    logic [3:0] m_tens, m_ones, s_tens, s_ones, cs_tens, cs_ones;
    logic       running, wrap;
    logic [23:0] digits;

    int checks   = 0;
    int failures = 0;

    // Reference model: time as total centiseconds, display as a snapshot of it.
    int ms = M_IDLE;
    int mt = 0;
    int md = 0;
    bit mrun = 1'b0;
    bit mwrap = 1'b0;

    always #5 clk = ~clk;

    assign digits = {m_tens, m_ones, s_tens, s_ones, cs_tens, cs_ones};

    stopwatch_timekeeper #(.MINUTE_MAX(MINUTE_MAX)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .start_stop (start_stop),
        .clear      (clear),
        .lap        (lap),
        .m_tens     (m_tens),
        .m_ones     (m_ones),
        .s_tens     (s_tens),
        .s_ones     (s_ones),
        .cs_tens    (cs_tens),
        .cs_ones    (cs_ones),
        .running    (running),
        .wrap       (wrap)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] to_digits(input int v);
        int m, s, c;
        m = v / 6000;
        s = (v / 100) % 60;
        c = v % 100;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    task automatic model_update(input bit r, input bit tk, input bit ss, input bit cl, input bit lp);
        int ns;
        if (r) begin
            ms = M_IDLE; mt = 0; md = 0; mrun = 1'b0; mwrap = 1'b0;
            return;
        end
        mwrap = 1'b0;
        if (tk && (ms == M_RUN || ms == M_LAP)) begin
            mt = mt + 1;
            if (mt == LIMIT) begin
                mt = 0;
                mwrap = 1'b1;
            end
        end
        ns = ms;
        case (ms)
            M_IDLE:  if (ss) ns = M_RUN;
            M_RUN:   if (ss) ns = M_PAUSE; else if (LAP_EN && lp) ns = M_LAP;
            M_PAUSE: if (cl) begin ns = M_IDLE; mt = 0; end else if (ss) ns = M_RUN;
            default: if (ss) ns = M_PAUSE; else if (lp) ns = M_RUN;
        endcase
        if (ns != M_LAP) md = mt;
        ms = ns;
        mrun = (ns == M_RUN) || (ns == M_LAP);
    endtask

    task automatic step(input bit r, input bit tk, input bit ss, input bit cl, input bit lp);
        reset = r; tick = tk; start_stop = ss; clear = cl; lap = lp;
        @(posedge clk);
        model_update(r, tk, ss, cl, lp);
        #1;
        check_eq("digits", 32'(digits), 32'(to_digits(md)));
        check_eq("running", 32'(running), 32'(mrun));
        check_eq("wrap", 32'(wrap), 32'(mwrap));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("reset_digits", 32'(digits), 32'h0);
        check_eq("reset_running", 32'(running), 32'h0);

        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        ticks(150);
        check_eq("run_150", 32'(digits), 32'h000150);
        check_eq("run_150_running", 32'(running), 32'h1);

        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        ticks(10);
        check_eq("pause_hold", 32'(digits), 32'h000150);
        check_eq("pause_running", 32'(running), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("clear_digits", 32'(digits), 32'h0);

        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        ticks(11999);
        check_eq("pre_wrap", 32'(digits), 32'h015999);
        ticks(1);
        check_eq("wrap_digits", 32'(digits), 32'h0);
        check_eq("wrap_pulse", 32'(wrap), 32'h1);
        check_eq("wrap_running", 32'(running), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("wrap_one_cycle", 32'(wrap), 32'h0);

        ticks(42);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("pause_42", 32'(digits), 32'h000042);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("clear_wins", 32'(digits), 32'h0);
        check_eq("clear_wins_running", 32'(running), 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("idle_tick_ignored", 32'(digits), 32'h0);
        check_eq("idle_start_running", 32'(running), 32'h1);

        ticks(200);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        ticks(300);
`ifdef STOPWATCH_LAP_EN
        check_eq("lap_frozen", 32'(digits), 32'h000200);
`else
        check_eq("lap_ignored", 32'(digits), 32'h000500);
`endif
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("lap_release", 32'(digits), 32'h000500);

        ticks(233);
        check_eq("pre_reset", 32'(digits), 32'h000733);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("mid_reset_digits", 32'(digits), 32'h0);
        check_eq("mid_reset_running", 32'(running), 32'h0);
        ticks(5);
        check_eq("post_reset_idle", 32'(digits), 32'h0);

        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 999) == 0,
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 24) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stopwatch_timekeeper.md
# stopwatch_timekeeper

Tick-driven stopwatch core. Consumes the 100 Hz single-cycle tick from the stopwatch prescaler counter and accumulates elapsed time as BCD minutes:seconds.centiseconds. A start/stop/clear state machine (plus optional lap hold) drives the values shown on the seven-segment display mux.

## Interface
- MINUTE_MAX, 59: highest minute value before wrap (1..59; the bench sets it small).
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- tick  input  1  one-cycle pulse, one per 10 ms, from the prescaler
- start_stop  input  1  debounced one-cycle pulse; toggles run/pause
- clear  input  1  debounced one-cycle pulse; zeroes time when not running
- lap  input  1  debounced one-cycle pulse; used only when STOPWATCH_LAP_EN is defined, ignored otherwise
- m_tens, m_ones, s_tens, s_ones, cs_tens, cs_ones  output  4 each  displayed BCD digits
- running  output  1  high in RUN and LAP
- wrap  output  1  one-cycle pulse when time rolls from MINUTE_MAX:59.99 to 00:00.00

## Operation
- Time registers: cs 00–99, s 00–59, m 00–MINUTE_MAX, all BCD. Each digit carries into the next, and each digit pair wraps at its maximum.
- Time advances by one centisecond on every tick sampled while in RUN or LAP. Ticks are ignored in IDLE and PAUSE.
- States and transitions:
  - IDLE (time zero): start_stop -> RUN.
  - RUN: start_stop -> PAUSE; lap -> LAP.
  - PAUSE: start_stop -> RUN; clear -> IDLE, with time zeroed.
  - LAP: lap -> RUN; start_stop -> PAUSE.
- clear is ignored in RUN and LAP.
- Simultaneous events:
  - clear and start_stop in the same cycle in PAUSE: clear wins (-> IDLE). In IDLE the same pair -> RUN.
  - A tick in the same cycle as a state change is counted or not according to the current (pre-edge) state. RUN + start_stop + tick counts the tick. IDLE + start_stop + tick does not.
- On wrap, the time becomes 00:00.00, wrap pulses for one cycle, and the state is unchanged.
- Reset at any point gives IDLE, all time registers 0, display registers 0, running=0, wrap=0.

## Timing
- All outputs are registered. Digits reflect a tick one cycle after the tick is sampled.
- running changes in the cycle after the triggering pulse.
- wrap is high in the same cycle the digits first show 00:00.00.
- Inputs are assumed synchronous to clk and exactly one cycle wide. A pulse held longer is treated as repeated events.
- Carry chain is combinational within one cycle. There is no multi-cycle ripple.

## Configuration
- STOPWATCH_LAP_EN defined:
  - LAP state exists.
  - In LAP, display registers hold the snapshot captured on the lap pulse while the internal time keeps counting.
  - Leaving LAP (lap -> RUN, or start_stop -> PAUSE) reloads the display from live time on the next cycle.
- Not defined:
  - lap input is ignored and there is no LAP state.
  - Display registers always follow live time.

## Structure
- Package stopwatch_pkg holds:
  - state enum (IDLE, RUN, PAUSE, LAP)
  - 4-bit BCD digit typedef
  - constants CS_MAX=99 and SEC_MAX=59
- Sub-module bcd_digit_pair: two-digit BCD counter with parameterised maximum, increment-enable input, synchronous clear, and carry-out on wrap. It is instantiated three times (cs, s, m), chained by carry.

## Test plan
- Reset, start_stop, then 150 ticks -> digits 00:01.50, running=1.
- In RUN at 00:01.50: start_stop, 10 ticks -> digits stay 00:01.50, running=0. Then clear -> 00:00.00, IDLE.
- MINUTE_MAX=1: run 11999 ticks to 01:59.99, then one more tick -> 00:00.00 with wrap high exactly one cycle, still running.
- In PAUSE at 00:00.42: clear and start_stop in the same cycle -> 00:00.00, running=0. In IDLE, start_stop and tick in the same cycle -> RUN with time still 00:00.00.
- STOPWATCH_LAP_EN: lap at 00:02.00, 300 ticks -> display 00:02.00. Lap again -> display 00:05.00 one cycle later.
- Reset asserted in RUN at 00:07.33 -> next cycle all digits 0, running=0. Subsequent ticks do not change the digits.
